axis_input_emu: RTL

- Parametrised multi-channel successor to the single-channel spinner used by the arcade tops.
- Converts held digital directions (keyboard/joystick/DB9/DB15) and MiSTer mouse/spinner deltas into per-channel WIDTH-bit position values for the game input ports.
- Each channel runs in one of three runtime modes: relative wrap (Tron/Two Tigers dial), absolute clamp (paddle), or auto return-to-centre (Kroozr-style analog stick).
- Digital motion uses frame-rate acceleration on the vsync strobe.

---
 rtl/axis_input_pkg.sv | 34 +++
 rtl/axis_channel.sv | 129 ++++++++++++
 rtl/axis_input_emu.sv | 124 ++++++++++++
 3 files changed

// File: rtl/axis_input_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_input_pkg
// Purpose  : Shared types, constants and the range-saturation helper used by
//            the axis input emulator and its per-channel slices.
// Revision : 1.0 - initial release
// ============================================================================
package axis_input_pkg;

  // Per-channel runtime mode; encoding 3 is reserved and handled as wrap.
  typedef enum logic [1:0] {
    AXIS_WRAP   = 2'd0,
    AXIS_CLAMP  = 2'd1,
    AXIS_CENTER = 2'd2
  } axis_mode_t;

  // Bits per channel on spin_in: [8] toggle, [7:0] signed delta.
  localparam int AXIS_SPIN_W = 9;

  // Saturate a signed value into the inclusive range [lo, hi].
  function automatic logic signed [31:0] axis_sat(
    input logic signed [31:0] val,
    input logic signed [31:0] lo,
    input logic signed [31:0] hi
  );
    logic signed [31:0] r;
    r = val;
    if (val < lo) r = lo;
    else if (val > hi) r = hi;
    return r;
  endfunction

endpackage : axis_input_pkg
`default_nettype wire

// File: rtl/axis_channel.sv
`default_nettype none
// ============================================================================
// Module   : axis_channel
// Purpose  : One axis: digital step acceleration, mouse toggle tracking,
//            wrap / clamp / return-to-centre arithmetic and position register.
// Revision : 1.0 - initial release
// ============================================================================
module axis_channel
  import axis_input_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 8,
  parameter int MOUSE_SHIFT = 0,
  parameter int CENTER      = 128,
  parameter int LIMIT_LO    = 0,
  parameter int LIMIT_HI    = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             strobe_evt,
  input  logic             minus,
  input  logic             plus,
  input  logic             spin_tog,
  input  logic [7:0]       spin_delta,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] pos_out,
  output logic             moved
);

  // Wide enough that pos + step + shifted mouse delta never overflows.
  localparam int SUM_W  = WIDTH + MOUSE_SHIFT + 10;
  localparam int STEP_W = $clog2(STEP_MAX + 1);

  localparam logic [STEP_W-1:0]       STEP_MIN_C = STEP_W'(STEP_MIN);
  localparam logic [STEP_W-1:0]       STEP_MAX_C = STEP_W'(STEP_MAX);
  localparam logic [WIDTH-1:0]        CENTER_C   = WIDTH'(CENTER);
  localparam logic [WIDTH-1:0]        RATE_C     = WIDTH'(STEP_MAX);
  localparam logic signed [SUM_W-1:0] CENTER_S   = SUM_W'(CENTER);
  localparam logic signed [SUM_W-1:0] RATE_S     = SUM_W'(STEP_MAX);

  logic [WIDTH-1:0]  pos_q, pos_d;
  logic              moved_q, moved_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              tog_ref_q, tog_ref_d;
  logic              tog_valid_q, tog_valid_d;

  logic                    mouse_evt;
  logic signed [SUM_W-1:0] pos_ext;
  logic signed [SUM_W-1:0] dig_delta;
  logic signed [SUM_W-1:0] mouse_delta;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] diff;
  logic [WIDTH-1:0]        toward;
  logic [WIDTH-1:0]        clamped;

  // Next-state computation for step, toggle reference and position.
  always_comb begin
    // The very first cycle after reset only learns the toggle level.
    mouse_evt   = tog_valid_q && (spin_tog != tog_ref_q);
    tog_ref_d   = spin_tog;
    tog_valid_d = 1'b1;

    pos_ext = $signed({{(SUM_W-WIDTH){1'b0}}, pos_q});

    mouse_delta = '0;
    if (mouse_evt) begin
      mouse_delta = $signed({{(SUM_W-8){spin_delta[7]}}, spin_delta}) <<< MOUSE_SHIFT;
    end

    // Exactly one direction held accelerates; none or both restarts the ramp.
    dig_delta = '0;
    step_d    = step_q;
    if (strobe_evt) begin
      if (plus ^ minus) begin
        dig_delta = $signed({{(SUM_W-STEP_W){1'b0}}, step_q});
        if (minus) dig_delta = -dig_delta;
        step_d = (step_q >= STEP_MAX_C) ? STEP_MAX_C : step_q + STEP_W'(1);
      end else begin
        step_d = STEP_MIN_C;
      end
    end

    sum     = pos_ext + dig_delta + mouse_delta;
    clamped = WIDTH'(axis_sat(32'(sum), LIMIT_LO, LIMIT_HI));

    // Return-to-centre target: one STEP_MAX stride, landing exactly on CENTER.
    diff = pos_ext - CENTER_S;
    if (diff > RATE_S)       toward = pos_q - RATE_C;
    else if (diff < -RATE_S) toward = pos_q + RATE_C;
    else                     toward = CENTER_C;

    pos_d = pos_q;
    if (strobe_evt || mouse_evt) begin
      case (mode)
        AXIS_CLAMP: pos_d = clamped;
        AXIS_CENTER: begin
          if (strobe_evt && !plus && !minus && (mouse_delta == '0)) pos_d = toward;
          else                                                       pos_d = clamped;
        end
        default: pos_d = sum[WIDTH-1:0];
      endcase
    end

    moved_d = (pos_d != pos_q);
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q       <= CENTER_C;
      moved_q     <= 1'b0;
      step_q      <= STEP_MIN_C;
      tog_ref_q   <= 1'b0;
      tog_valid_q <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      moved_q     <= moved_d;
      step_q      <= step_d;
      tog_ref_q   <= tog_ref_d;
      tog_valid_q <= tog_valid_d;
    end
  end

  assign pos_out = pos_q;
  assign moved   = moved_q;

endmodule : axis_channel
`default_nettype wire

// File: rtl/axis_input_emu.sv
`default_nettype none
// ============================================================================
// Module   : axis_input_emu
// Purpose  : Multi-channel spinner / paddle / stick position emulator. Holds
//            the shared vsync edge detect, optional input synchronisers and
//            port slicing; per-axis work lives in axis_channel.
// Options  : AXIS_INPUT_SYNC_EN - 2-flop synchronise minus, plus, strobe and
//            the spin toggle bits (adds 2 clk latency).
// Revision : 1.0 - initial release
// ============================================================================
module axis_input_emu
  import axis_input_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 8,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 8,
  parameter int MOUSE_SHIFT = 0,
  parameter int CENTER      = 128,
  parameter int LIMIT_LO    = 0,
  parameter int LIMIT_HI    = 255
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            strobe,
  input  logic [CHANNELS-1:0]             minus,
  input  logic [CHANNELS-1:0]             plus,
  input  logic [CHANNELS*AXIS_SPIN_W-1:0] spin_in,
  input  logic [CHANNELS*2-1:0]           mode,
  output logic [CHANNELS*WIDTH-1:0]       pos_out,
  output logic [CHANNELS-1:0]             moved
);

  logic [CHANNELS-1:0] tog_raw;
  logic [CHANNELS-1:0] minus_s, plus_s, tog_s;
  logic                strobe_s;
  logic                strobe_prev_q, strobe_prev_d;
  logic                strobe_evt;

  // Gather the toggle bit of every channel's spin word.
  always_comb begin
    tog_raw = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      tog_raw[c] = spin_in[c*AXIS_SPIN_W + 8];
    end
  end

`ifdef AXIS_INPUT_SYNC_EN
  logic [CHANNELS-1:0] minus_s1_q, minus_s2_q;
  logic [CHANNELS-1:0] plus_s1_q, plus_s2_q;
  logic [CHANNELS-1:0] tog_s1_q, tog_s2_q;
  logic                strobe_s1_q, strobe_s2_q;

  // Two-flop synchronisers for inputs arriving from the joystick clock domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      minus_s1_q  <= '0;
      minus_s2_q  <= '0;
      plus_s1_q   <= '0;
      plus_s2_q   <= '0;
      tog_s1_q    <= '0;
      tog_s2_q    <= '0;
      strobe_s1_q <= 1'b1;
      strobe_s2_q <= 1'b1;
    end else begin
      minus_s1_q  <= minus;
      minus_s2_q  <= minus_s1_q;
      plus_s1_q   <= plus;
      plus_s2_q   <= plus_s1_q;
      tog_s1_q    <= tog_raw;
      tog_s2_q    <= tog_s1_q;
      strobe_s1_q <= strobe;
      strobe_s2_q <= strobe_s1_q;
    end
  end

  assign minus_s  = minus_s2_q;
  assign plus_s   = plus_s2_q;
  assign tog_s    = tog_s2_q;
  assign strobe_s = strobe_s2_q;
`else
  assign minus_s  = minus;
  assign plus_s   = plus;
  assign tog_s    = tog_raw;
  assign strobe_s = strobe;
`endif

  // Rising-edge detect; the reset value of 1 hides a strobe already high.
  always_comb begin
    strobe_prev_d = strobe_s;
    strobe_evt    = strobe_s && !strobe_prev_q;
  end

  // Previous-strobe register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) strobe_prev_q <= 1'b1;
    else          strobe_prev_q <= strobe_prev_d;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    axis_channel #(
      .WIDTH      (WIDTH),
      .STEP_MIN   (STEP_MIN),
      .STEP_MAX   (STEP_MAX),
      .MOUSE_SHIFT(MOUSE_SHIFT),
      .CENTER     (CENTER),
      .LIMIT_LO   (LIMIT_LO),
      .LIMIT_HI   (LIMIT_HI)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .strobe_evt(strobe_evt),
      .minus     (minus_s[c]),
      .plus      (plus_s[c]),
      .spin_tog  (tog_s[c]),
      .spin_delta(spin_in[c*AXIS_SPIN_W +: 8]),
      .mode      (mode[c*2 +: 2]),
      .pos_out   (pos_out[c*WIDTH +: WIDTH]),
      .moved     (moved[c])
    );
  end

endmodule : axis_input_emu
`default_nettype wire
